// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between the execute/memory stage and a word-only
// data memory (combinational read, synchronous full-word write).
//   - Byte/halfword loads: lane extract plus sign/zero extension, 1-cycle latency.
//   - Word stores: written in the accept cycle, response the next cycle.
//   - Byte/halfword stores: read-modify-write through a merge buffer, with
//     one WRITE stall cycle.
//   - Misaligned accesses and the reserved size return resp_err and never
//     touch memory.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_size         request type; size 0=B, 1=H, 2=W, 3=reserved
//   req_unsigned             zero-extend loads when set
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid               single-cycle completion pulse
//   resp_rdata, resp_err     load result, error flag
//   mem_we, mem_addr         data memory write enable, word-aligned address
//   mem_wdata, mem_rdata     data memory write word, read word
module lsu_rmw #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                accept;
  logic                misal;
  logic [4:0]          sh_b;
  logic [4:0]          sh_h;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;
  logic [ADDR_W-1:0]   word_addr;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  // Bit offsets of the addressed byte / halfword lane (little-endian).
  assign sh_b = {req_addr[1:0], 3'b000};
  assign sh_h = {req_addr[1], 4'b0000};

  always_comb begin
    misal = 1'b0;
    case (req_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = req_addr[0];
      2'd2:    misal = (req_addr[1:0] != 2'b00);
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    lane_b   = 8'(mem_rdata >> sh_b);
    lane_h   = 16'(mem_rdata >> sh_h);
    load_ext = mem_rdata;
    case (req_size)
      2'd0:    load_ext = req_unsigned ? {{(DATA_W-8){1'b0}}, lane_b}
                                       : {{(DATA_W-8){lane_b[7]}}, lane_b};
      2'd1:    load_ext = req_unsigned ? {{(DATA_W-16){1'b0}}, lane_h}
                                       : {{(DATA_W-16){lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Clear the target lane of the current memory word, then OR in the
  // shifted store data; only meaningful for byte/halfword stores.
  always_comb begin
    merged = mem_rdata;
    case (req_size)
      2'd0: merged = (mem_rdata & ~({{(DATA_W-8){1'b0}}, 8'hFF} << sh_b))
                   | ({{(DATA_W-8){1'b0}}, req_wdata[7:0]} << sh_b);
      2'd1: merged = (mem_rdata & ~({{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_h))
                   | ({{(DATA_W-16){1'b0}}, req_wdata[15:0]} << sh_h);
      default: merged = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    merge_d = merge_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misal) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else if (!req_we) begin
            valid_d = 1'b1;
            rdata_d = load_ext;
          end else if (req_size == 2'd2) begin
            valid_d = 1'b1;
          end else begin
            state_d = WRITE;
            addr_d  = word_addr;
            merge_d = merged;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Word stores write in the accept cycle; sub-word stores write the merge
  // buffer during WRITE. Reset forces IDLE, so a pending RMW write drops at once.
  assign mem_we    = (state_q == WRITE)
                   | (accept & req_we & (req_size == 2'd2) & ~misal);
  assign mem_addr  = (state_q == WRITE) ? addr_q : word_addr;
  assign mem_wdata = (state_q == WRITE) ? merge_q : req_wdata;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: directed requests with hand-computed results; the
// response and memory-write scoreboards are consumed by independent monitors.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory model: combinational read, posedge write; poke preloads words.
  logic [31:0] mem [1024] = '{default: '0};
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [31:0] poke_d = '0;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_d;
    else if (mem_we && !rst) mem[mem_addr[11:2]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    last_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: outputs are registered, so sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (rq.size() == 0) begin
        chk("unexpected resp_valid", 32'(resp_valid), 32'd0);
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Write monitor: sample at the edge where the memory actually commits.
  always @(posedge clk) begin
    if (!rst && mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected mem_we", 32'(mem_we), 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("mem_addr", mem_addr, w.addr);
        chk("mem_wdata", mem_wdata, w.data);
      end
    end
  end

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
    poke_en  = 1'b1;
    poke_idx = byte_addr[11:2];
    poke_d   = data;
    @(posedge clk);
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  // Drive a request at a negedge, wait (bounded) for ready, record the
  // expected response, and return at the negedge after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    resp_t e;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    last_wait    = 0;
    while (!req_ready && last_wait < 8) begin
      @(negedge clk);
      last_wait++;
    end
    if (!req_ready) chk("req_ready timeout", 32'(req_ready), 32'd1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + lat;
    rq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", 32'(req_ready), 32'd1);

    poke(32'h100, 32'h8899AABB);
    poke(32'h10C, 32'hCAFEF00D);

    // Sub-word loads with sign/zero extension, back-to-back.
    issue(1'b0, 2'd0, 1'b0, 32'h102, '0, 32'hFFFFFF99, 1'b0, 1);
    issue(1'b0, 2'd0, 1'b1, 32'h102, '0, 32'h00000099, 1'b0, 1);
    issue(1'b0, 2'd1, 1'b1, 32'h100, '0, 32'h0000AABB, 1'b0, 1);
    issue(1'b0, 2'd1, 1'b0, 32'h100, '0, 32'hFFFFAABB, 1'b0, 1);
    issue(1'b0, 2'd0, 1'b1, 32'h103, '0, 32'h00000088, 1'b0, 1);
    issue(1'b0, 2'd0, 1'b0, 32'h100, '0, 32'hFFFFFFBB, 1'b0, 1);
    idle();
    @(negedge clk);

    // Load, byte store RMW, load of the same word.
    poke(32'h100, 32'h11223344);
    issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 32'h11223344, 1'b0, 1);
    expect_write(32'h100, 32'h11225A44);
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'hABCDEF5A, 32'h0, 1'b0, 2);
    chk("req_ready in WRITE", 32'(req_ready), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 32'h11225A44, 1'b0, 1);
    chk("stall cycles after byte store", last_wait, 32'd1);
    idle();
    @(negedge clk);

    // Halfword store into a zero word, then signed halfword load.
    expect_write(32'h204, 32'hBEEF0000);
    issue(1'b1, 2'd1, 1'b0, 32'h206, 32'h0000BEEF, 32'h0, 1'b0, 2);
    issue(1'b0, 2'd1, 1'b0, 32'h206, '0, 32'hFFFFBEEF, 1'b0, 1);
    issue(1'b0, 2'd1, 1'b1, 32'h204, '0, 32'h00000000, 1'b0, 1);
    idle();
    @(negedge clk);
    chk("mem[0x204]", mem[32'h204 >> 2], 32'hBEEF0000);

    // Misaligned and reserved-size requests: errors, no memory writes.
    issue(1'b0, 2'd2, 1'b0, 32'h303, '0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'd1, 1'b0, 32'h301, 32'h1234, 32'h0, 1'b1, 1);
    issue(1'b1, 2'd2, 1'b0, 32'h302, 32'h5678, 32'h0, 1'b1, 1);
    issue(1'b0, 2'd3, 1'b0, 32'h100, '0, 32'h0, 1'b1, 1);
    idle();
    @(negedge clk);
    chk("mem[0x300] untouched", mem[32'h300 >> 2], 32'h0);

    // Consecutive word stores: no stalls, one write per cycle.
    expect_write(32'h0, 32'hA);
    expect_write(32'h4, 32'hB);
    expect_write(32'h8, 32'hC);
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'hA, 32'h0, 1'b0, 1);
    chk("word store 0 wait", last_wait, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'hB, 32'h0, 1'b0, 1);
    chk("word store 1 wait", last_wait, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hC, 32'h0, 1'b0, 1);
    chk("word store 2 wait", last_wait, 32'd0);
    idle();
    @(negedge clk);
    chk("mem[0x0]", mem[0], 32'hA);
    chk("mem[0x4]", mem[1], 32'hB);
    chk("mem[0x8]", mem[2], 32'hC);

    // Reset during WRITE discards the pending RMW write.
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h10D;
    req_wdata    = 32'h77;
    chk("ready before aborted store", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    #1;
    chk("mem_we drops with rst", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("ready after reset release", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("aborted word unchanged", mem[32'h10C >> 2], 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h10C, '0, 32'hCAFEF00D, 1'b0, 1);
    idle();

    // Drain outstanding expectations within a bounded number of cycles.
    for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pending responses", rq.size(), 32'd0);
    chk("pending writes", wq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the execute/memory pipeline stage and the word-only data memory.
- The data memory offers a combinational word read and a synchronous full-word write.
- This block adds byte and halfword stores using read-modify-write, and byte/halfword loads with sign or zero extension.
- It also detects misaligned accesses and drives a valid/ready handshake so the pipeline can stall during the extra RMW cycle.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  pipeline presents a memory request
- req_ready  output  1  block accepts request this cycle (acceptance = req_valid & req_ready)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as misaligned)
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle pulse: request completed
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  valid with resp_valid: misaligned or reserved size
- mem_we  output  1  data memory write enable
- mem_addr  output  ADDR_W  data memory byte address (bits [1:0] driven 0)
- mem_wdata  output  32  data memory write word
- mem_rdata  input  32  data memory combinational read word

Behaviour:
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0. The latched address and merge buffer clear to 0.
- Alignment:
  - Byte accesses are always aligned.
  - Halfword accesses are misaligned if addr[0] = 1.
  - Word accesses are misaligned if addr[1:0] != 0.
  - size = 3 is an error.
- Lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0]. The halfword lane is selected by addr[1].
- FSM has two states: IDLE and WRITE.
- IDLE:
  - req_ready = 1.
  - mem_addr = {req_addr[ADDR_W-1:2], 2'b00}.
- Accepted load in IDLE:
  - Extract the lane from mem_rdata in the same cycle and extend it per req_unsigned.
  - Register the result into resp_rdata; resp_valid = 1 the next cycle.
  - Latency is 1 cycle; a new request can be accepted every cycle.
- Accepted word store in IDLE:
  - mem_we = 1 combinationally in the same cycle, with mem_wdata = req_wdata.
  - resp_valid the next cycle, with resp_rdata = 0. Stay in IDLE.
- Accepted byte or halfword store in IDLE:
  - mem_we = 0.
  - Merge the shifted req_wdata into the target lane of mem_rdata and latch the result into the merge buffer. Latch the word address.
  - Go to WRITE.
- WRITE:
  - req_ready = 0; any req_valid is held off.
  - mem_we = 1, mem_addr = latched address, mem_wdata = merge buffer.
  - Return to IDLE on the next edge, asserting resp_valid in the same cycle the FSM is back in IDLE.
  - Total store latency is 2 cycles, with 1 stall cycle.
- Misaligned or reserved request:
  - Accepted in IDLE with no memory access (mem_we = 0).
  - Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0.
- resp_valid is a single-cycle pulse. There is no resp_ready; the consumer must sample it.
- The combinational mem_we in IDLE is gated by req_valid & req_we & size==2 & aligned. No glitch-sensitive logic is permitted beyond that.
- Reset asserted mid-WRITE:
  - State returns to IDLE asynchronously and mem_we drops immediately.
  - The pending RMW write is discarded and no resp_valid is produced.
- Back-to-back: load, then sub-word store, then load to the same word. The second load is accepted in the cycle after WRITE and must observe the merged data.

Test Plan:
- Memory word 0x100 = 0x8899AABB. Load byte at 0x102, signed -> resp_rdata = 0xFFFFFF99 one cycle later. The same load unsigned -> 0x00000099.
- Store byte 0x5A at 0x101 into word 0x11223344 -> req_ready low for 1 cycle, mem_we in the WRITE cycle with mem_wdata = 0x11225A44. A subsequent word load returns 0x11225A44.
- Store halfword 0xBEEF at 0x206 into word 0x00000000 -> memory word = 0xBEEF0000. A signed halfword load at 0x206 returns 0xFFFFBEEF.
- Word load at 0x303 and halfword store at 0x301 -> resp_err = 1, resp_rdata = 0, mem_we never asserted.
- Word stores 0xA, 0xB, 0xC to 0x0, 0x4, 0x8 on consecutive cycles -> three mem_we cycles, req_ready stays high, three resp_valid pulses each 1 cycle after acceptance.
- Byte store accepted, then rst asserted during WRITE -> mem_we falls with rst, the target word is unchanged, no resp_valid, req_ready = 1 after reset release.
